// File: rtl/alu_commit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_commit_pkg
// Purpose  : Shared definitions for the ALU result commit stage: commit-kind
//            encodings, condition-flag bit positions and the width of one
//            buffered FIFO entry.
// Revision : 1.0 - initial release
// ============================================================================
package alu_commit_pkg;

  // How a buffered ALU result retires.
  typedef enum logic [1:0] {
    KIND_GPR       = 2'b00,
    KIND_HILO      = 2'b01,
    KIND_FLAGS     = 2'b10,
    KIND_GPR_FLAGS = 2'b11
  } commit_kind_e;

  // Bit positions inside the {N,Z,C,V} condition register.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Field widths of one FIFO entry (besides the three WIDTH-bit words and
  // the AW-bit destination).
  localparam int KIND_W  = 2;
  localparam int SIGN_W  = 1;
  localparam int FLAGS_W = 4;

  // Entry layout (MSB..LSB):
  //   {respuesta, out_high, out_low, dest, kind, sign, N, Z, C, V}
  function automatic int entry_width(input int width, input int aw);
    return 3 * width + aw + KIND_W + SIGN_W + FLAGS_W;
  endfunction

endpackage : alu_commit_pkg
`default_nettype wire

// File: rtl/alu_commit_fifo.sv
`default_nettype none
// ============================================================================
// Module   : alu_commit_fifo
// Purpose  : DEPTH-entry FIFO holding flattened ALU results for the commit
//            stage. Registered count; full/empty derive only from the count so
//            the accept side never depends combinationally on the pop side.
// Ports    : clk, rst_n      - clock, asynchronous active-low reset
//            push, push_data - write request and entry (ignored when full)
//            pop             - retire head entry (ignored when empty)
//            head_data       - current head entry
//            full, empty     - occupancy status
// Revision : 1.0 - initial release
// ============================================================================
module alu_commit_fifo #(
  parameter int DEPTH = 2,
  parameter int EW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [EW-1:0] push_data,
  input  logic          pop,
  output logic [EW-1:0] head_data,
  output logic          full,
  output logic          empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] c_FULL_CNT = CW'(DEPTH);

  logic [EW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_push_ok;
  logic w_pop_ok;

  assign w_push_ok = push & ~full;
  assign w_pop_ok  = pop & ~empty;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only ever read after being written.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= push_data;
  end

  assign head_data = r_mem[r_rd_ptr];
  assign full      = (r_count == c_FULL_CNT);
  assign empty     = (r_count == '0);

endmodule : alu_commit_fifo
`default_nettype wire

// File: rtl/alu_result_commit.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_commit
// Purpose  : Commit stage behind the ALU. Buffers ALU results in a small FIFO
//            and retires them in order: GPR writes through a valid/ready port,
//            HI/LO register updates and condition-flag updates.
// Ports    : clk, rst_n                 - clock, async active-low reset
//            in_valid/in_ready          - ALU result handshake
//            in_respuesta, in_out_high, in_out_low, in_dest, in_kind,
//            in_sign, in_Z/N/C/V        - ALU result fields
//            wb_valid/wb_ready, wb_addr, wb_data - register-file write port
//            hi_reg, lo_reg             - architectural HI/LO
//            flags                      - {N,Z,C,V} condition register
//            trap                       - overflow trap pulse
//            busy                       - results still buffered
// Config   : ALU_COMMIT_TRAP_EN - signed GPR results with V=1 suppress the
//            register write and pulse trap the cycle after retirement.
//            Without it, trap is tied low and V is only recorded in flags.
// Revision : 1.0 - initial release
// ============================================================================
module alu_result_commit
  import alu_commit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_respuesta,
  input  logic [WIDTH-1:0] in_out_high,
  input  logic [WIDTH-1:0] in_out_low,
  input  logic [AW-1:0]    in_dest,
  input  logic [1:0]       in_kind,
  input  logic             in_sign,
  input  logic             in_Z,
  input  logic             in_N,
  input  logic             in_C,
  input  logic             in_V,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [AW-1:0]    wb_addr,
  output logic [WIDTH-1:0] wb_data,
  output logic [WIDTH-1:0] hi_reg,
  output logic [WIDTH-1:0] lo_reg,
  output logic [3:0]       flags,
  output logic             trap,
  output logic             busy
);

  localparam int c_EW = entry_width(WIDTH, AW);

  logic [c_EW-1:0]  w_push_data;
  logic [c_EW-1:0]  w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  logic [WIDTH-1:0] w_h_resp;
  logic [WIDTH-1:0] w_h_high;
  logic [WIDTH-1:0] w_h_low;
  logic [AW-1:0]    w_h_dest;
  logic [1:0]       w_h_kind_raw;
  commit_kind_e     w_h_kind;
  logic             w_h_sign;
  logic [3:0]       w_h_flags;

  logic             w_is_gpr;
  logic             w_trap_hit;
  logic             w_wants_wb;

  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [3:0]       r_flags;

  // ---------------------------------------------------------------------------
  // Buffering
  // ---------------------------------------------------------------------------
  assign w_push_data = {in_respuesta, in_out_high, in_out_low, in_dest,
                        in_kind, in_sign, in_N, in_Z, in_C, in_V};

  // in_ready comes from the registered count only, so a full FIFO refuses a
  // push even in the cycle its head retires.
  assign in_ready = ~w_full;
  assign w_push   = in_valid & in_ready;
  assign busy     = ~w_empty;

  alu_commit_fifo #(
    .DEPTH (DEPTH),
    .EW    (c_EW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .head_data (w_head),
    .full      (w_full),
    .empty     (w_empty)
  );

  assign {w_h_resp, w_h_high, w_h_low, w_h_dest,
          w_h_kind_raw, w_h_sign, w_h_flags} = w_head;
  assign w_h_kind = commit_kind_e'(w_h_kind_raw);

  // ---------------------------------------------------------------------------
  // Retirement decode
  // ---------------------------------------------------------------------------
  assign w_is_gpr = (w_h_kind == KIND_GPR) || (w_h_kind == KIND_GPR_FLAGS);

`ifdef ALU_COMMIT_TRAP_EN
  logic r_trap;

  assign w_trap_hit = w_is_gpr & w_h_sign & w_h_flags[FLAG_V];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_trap <= 1'b0;
    else        r_trap <= w_pop & w_trap_hit;
  end

  assign trap = r_trap;
`else
  logic w_unused_sign;

  assign w_trap_hit    = 1'b0;
  assign w_unused_sign = w_h_sign;
  assign trap          = 1'b0;
`endif

  // Writes to r0 and trapped writes retire without touching the port.
  assign w_wants_wb = w_is_gpr & (w_h_dest != '0) & ~w_trap_hit;
  assign wb_valid   = ~w_empty & w_wants_wb;
  assign w_pop      = ~w_empty & (~w_wants_wb | wb_ready);

  // Head is frozen while stalled, so address/data stay stable; zero otherwise.
  assign wb_addr = wb_valid ? w_h_dest : '0;
  assign wb_data = wb_valid ? w_h_resp : '0;

  // ---------------------------------------------------------------------------
  // Architectural HI/LO and condition flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi    <= '0;
      r_lo    <= '0;
      r_flags <= '0;
    end else if (w_pop) begin
      if (w_h_kind == KIND_HILO) begin
        r_hi <= w_h_high;
        r_lo <= w_h_low;
      end
      if ((w_h_kind == KIND_FLAGS) || (w_h_kind == KIND_GPR_FLAGS)) begin
        r_flags <= w_h_flags;
      end
    end
  end

  assign hi_reg = r_hi;
  assign lo_reg = r_lo;
  assign flags  = r_flags;

endmodule : alu_result_commit
`default_nettype wire

// File: tb/tb_alu_result_commit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_result_commit
// Purpose  : Self-checking bench for alu_result_commit. Directed scenarios
//            followed by randomized traffic, all compared against a queue-based
//            reference model of the commit stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_result_commit;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int AW    = 5;

`ifdef ALU_COMMIT_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] resp;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [4:0]  dest;
    logic [1:0]  kind;
    logic        sign;
    logic        n;
    logic        z;
    logic        c;
    logic        v;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_respuesta = '0;
  logic [WIDTH-1:0] in_out_high = '0;
  logic [WIDTH-1:0] in_out_low = '0;
  logic [AW-1:0]    in_dest = '0;
  logic [1:0]       in_kind = '0;
  logic             in_sign = 1'b0;
  logic             in_Z = 1'b0;
  logic             in_N = 1'b0;
  logic             in_C = 1'b0;
  logic             in_V = 1'b0;
  logic             wb_valid;
  logic             wb_ready = 1'b0;
  logic [AW-1:0]    wb_addr;
  logic [WIDTH-1:0] wb_data;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic [3:0]       flags;
  logic             trap;
  logic             busy;

  alu_result_commit #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_respuesta (in_respuesta),
    .in_out_high  (in_out_high),
    .in_out_low   (in_out_low),
    .in_dest      (in_dest),
    .in_kind      (in_kind),
    .in_sign      (in_sign),
    .in_Z         (in_Z),
    .in_N         (in_N),
    .in_C         (in_C),
    .in_V         (in_V),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .hi_reg       (hi_reg),
    .lo_reg       (lo_reg),
    .flags        (flags),
    .trap         (trap),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Reference model state
  ent_t        q[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [3:0]  m_flags;
  logic        m_trap;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_gpr_kind(input ent_t e);
    return (e.kind == 2'b00) || (e.kind == 2'b11);
  endfunction

  function automatic bit m_trap_hit(input ent_t e);
    return TRAP_EN && is_gpr_kind(e) && e.sign && e.v;
  endfunction

  function automatic bit m_writes(input ent_t e);
    return is_gpr_kind(e) && (e.dest != 5'd0) && !m_trap_hit(e);
  endfunction

  function automatic ent_t mk(input logic [1:0] kind, input logic [4:0] dest,
                              input logic [31:0] resp, input logic [31:0] hi,
                              input logic [31:0] lo, input logic sign,
                              input logic [3:0] nzcv);
    ent_t e;
    e.kind = kind; e.dest = dest; e.resp = resp; e.hi = hi; e.lo = lo;
    e.sign = sign; e.n = nzcv[3]; e.z = nzcv[2]; e.c = nzcv[1]; e.v = nzcv[0];
    return e;
  endfunction

  function automatic ent_t rnd_ent();
    logic [4:0] d;
    d = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    return mk(2'($urandom), d, $urandom, $urandom, $urandom,
              1'($urandom), 4'($urandom));
  endfunction

  task automatic model_clear();
    q.delete();
    m_hi = '0; m_lo = '0; m_flags = '0; m_trap = 1'b0;
  endtask

  // Called just after a rising edge: drive one cycle of stimulus, check all
  // outputs mid-cycle against the model, then advance the model at the edge.
  task automatic step(input bit v, input ent_t e, input bit rdy);
    bit   exp_ready, exp_wbv, do_pop, do_push;
    ent_t h;
    in_valid = v; in_respuesta = e.resp; in_out_high = e.hi; in_out_low = e.lo;
    in_dest = e.dest; in_kind = e.kind; in_sign = e.sign;
    in_N = e.n; in_Z = e.z; in_C = e.c; in_V = e.v;
    wb_ready = rdy;
    @(negedge clk);
    exp_ready = (q.size() < DEPTH);
    exp_wbv   = (q.size() != 0) && m_writes(q[0]);
    chk("in_ready", 64'(in_ready), 64'(exp_ready));
    chk("busy", 64'(busy), 64'(q.size() != 0));
    chk("wb_valid", 64'(wb_valid), 64'(exp_wbv));
    if (exp_wbv) begin
      chk("wb_addr", 64'(wb_addr), 64'(q[0].dest));
      chk("wb_data", 64'(wb_data), 64'(q[0].resp));
    end
    chk("hi_reg", 64'(hi_reg), 64'(m_hi));
    chk("lo_reg", 64'(lo_reg), 64'(m_lo));
    chk("flags", 64'(flags), 64'(m_flags));
    chk("trap", 64'(trap), 64'(m_trap));
    do_pop  = (q.size() != 0) && (!exp_wbv || rdy);
    do_push = v && exp_ready;
    @(posedge clk);
    m_trap = 1'b0;
    if (do_pop) begin
      h = q.pop_front();
      if (h.kind == 2'b01) begin
        m_hi = h.hi;
        m_lo = h.lo;
      end
      if (h.kind[1]) m_flags = {h.n, h.z, h.c, h.v};
      m_trap = m_trap_hit(h);
    end
    if (do_push) q.push_back(e);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_wb_addr", 64'(wb_addr), 64'd0);
    chk("rst_wb_data", 64'(wb_data), 64'd0);
    chk("rst_hi", 64'(hi_reg), 64'd0);
    chk("rst_lo", 64'(lo_reg), 64'd0);
    chk("rst_flags", 64'(flags), 64'd0);
    chk("rst_trap", 64'(trap), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  ent_t idle;

  initial begin
    idle = mk(2'b00, 5'd0, '0, '0, '0, 1'b0, 4'b0000);
    do_reset();

    // Single GPR write, wb_ready held high
    step(1'b1, mk(2'b00, 5'd5, 32'hDEADBEEF, '0, '0, 1'b0, 4'b0000), 1'b1);
    chk("t1_wb_valid", 64'(wb_valid), 64'd1);
    chk("t1_wb_addr", 64'(wb_addr), 64'd5);
    chk("t1_wb_data", 64'(wb_data), 64'hDEADBEEF);
    step(1'b0, idle, 1'b1);
    chk("t1_busy_fall", 64'(busy), 64'd0);

    // Back-pressure: third push refused while full
    step(1'b1, mk(2'b00, 5'd10, 32'h11111111, '0, '0, 1'b0, 4'b0000), 1'b0);
    step(1'b1, mk(2'b00, 5'd11, 32'h22222222, '0, '0, 1'b0, 4'b0000), 1'b0);
    chk("t2_full_ready", 64'(in_ready), 64'd0);
    step(1'b1, mk(2'b00, 5'd12, 32'h33333333, '0, '0, 1'b0, 4'b0000), 1'b0);
    chk("t2_stall_addr", 64'(wb_addr), 64'd10);
    chk("t2_stall_data", 64'(wb_data), 64'h11111111);
    step(1'b0, idle, 1'b1);
    chk("t2_second_addr", 64'(wb_addr), 64'd11);
    step(1'b0, idle, 1'b1);
    step(1'b0, idle, 1'b1);
    chk("t2_drained", 64'(busy), 64'd0);

    // HI/LO update
    step(1'b1, mk(2'b01, 5'd3, 32'hAAAA5555, 32'h00000001, 32'h80000000, 1'b0, 4'b0000), 1'b1);
    chk("t3_no_wb", 64'(wb_valid), 64'd0);
    step(1'b0, idle, 1'b1);
    chk("t3_hi", 64'(hi_reg), 64'h00000001);
    chk("t3_lo", 64'(lo_reg), 64'h80000000);

    // GPR_FLAGS to r0: flags only
    step(1'b1, mk(2'b11, 5'd0, 32'h12345678, '0, '0, 1'b0, 4'b1010), 1'b1);
    chk("t4_no_wb", 64'(wb_valid), 64'd0);
    step(1'b0, idle, 1'b1);
    chk("t4_flags", 64'(flags), 64'b1010);

    // Signed overflow on a GPR write
    step(1'b1, mk(2'b00, 5'd7, 32'h7FFF0000, '0, '0, 1'b1, 4'b0001), 1'b1);
    chk("t5_wb_valid", 64'(wb_valid), 64'(!TRAP_EN));
    step(1'b0, idle, 1'b1);
    chk("t5_trap_pulse", 64'(trap), 64'(TRAP_EN));
    step(1'b0, idle, 1'b1);
    chk("t5_trap_clear", 64'(trap), 64'd0);

    // Reset with entries buffered and a write pending
    step(1'b1, mk(2'b00, 5'd20, 32'hCAFEF00D, '0, '0, 1'b0, 4'b0000), 1'b0);
    step(1'b1, mk(2'b01, 5'd21, '0, 32'h5, 32'h6, 1'b0, 4'b0000), 1'b0);
    chk("t6_pending", 64'(wb_valid), 64'd1);
    do_reset();
    step(1'b0, idle, 1'b1);
    step(1'b0, idle, 1'b1);
    step(1'b0, idle, 1'b1);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 79) == 0) do_reset();
      else step($urandom_range(0, 3) != 0, rnd_ent(), $urandom_range(0, 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_alu_result_commit
`default_nettype wire

// File: doc/alu_result_commit.md
# alu_result_commit

Commit stage directly downstream of the ALU. Buffers each ALU result (respuesta, outHigh/outLow, Z/N/C/V) in a small FIFO, decoupling the combinational ALU from register-file write timing. Drives the register-file write port through a valid/ready handshake and owns the architectural HI/LO registers and the condition-flag register.

## Interface
Parameters:
- WIDTH, 32, datapath width
- DEPTH, 2, FIFO entries (power of two, ≥2)
- AW, 5, register-file address width

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  ALU result offered
- in_ready  out  1  stage can accept; equals count < DEPTH
- in_respuesta  in  WIDTH  ALU main result
- in_out_high  in  WIDTH  upper product/remainder word
- in_out_low  in  WIDTH  lower product/quotient word
- in_dest  in  AW  destination GPR
- in_kind  in  2  commit kind: 00 GPR, 01 HILO, 10 FLAGS, 11 GPR_FLAGS
- in_sign  in  1  signed operation (trap qualifier)
- in_Z, in_N, in_C, in_V  in  1 each  ALU flags
- wb_valid  out  1  GPR write pending
- wb_ready  in  1  register file accepts write
- wb_addr  out  AW  write address
- wb_data  out  WIDTH  write data
- hi_reg, lo_reg  out  WIDTH  architectural HI/LO
- flags  out  4  {N,Z,C,V} condition register
- trap  out  1  one-cycle overflow trap pulse (see Configuration)
- busy  out  1  FIFO non-empty

## Operation
- Push on in_valid & in_ready; entry stores all in_* fields. No push when full; in_ready is never combinationally dependent on pop.
- Head entry retired ("pop") by kind:
  - GPR / GPR_FLAGS with in_dest ≠ 0: wb_valid=1, wb_addr/wb_data from head; pop on wb_ready.
  - GPR / GPR_FLAGS with in_dest = 0: no wb_valid; pops in one cycle.
  - HILO: hi_reg←out_high, lo_reg←out_low at pop; pops in one cycle, no wb.
  - FLAGS: flags←{N,Z,C,V} at pop; pops in one cycle.
  - GPR_FLAGS: flags updated on the same edge as the GPR pop.
- In-order retirement; one entry per cycle maximum.
- Simultaneous push and pop: both occur; count unchanged. Push and pop on full: pop completes, push refused that cycle (in_ready was 0).
- Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- wb_addr/wb_data stable while wb_valid=1 and wb_ready=0.

## Timing
- Reset (async assert, sync deassert by caller): FIFO empty, in_ready=1, wb_valid=0, wb_addr=0, wb_data=0, hi_reg=0, lo_reg=0, flags=0, trap=0, busy=0.
- Latency: entry pushed at edge t appears at head after t; wb_valid asserts cycle t+1 earliest; HILO/FLAGS state visible after edge t+1.
- Throughput: one commit/cycle with wb_ready held 1.
- Reset mid-operation: all buffered entries discarded, no partial writes; HI/LO/flags return to 0.

## Configuration
- ALU_COMMIT_TRAP_EN defined: a GPR or GPR_FLAGS head with in_sign=1 and V=1 pops without wb_valid (write suppressed), flags still updated for GPR_FLAGS, trap pulses high exactly the cycle after pop.
- Undefined: V only recorded in flags; GPR written normally; trap tied 0.

## Structure
- Package alu_commit_pkg: kind encodings (KIND_GPR, KIND_HILO, KIND_FLAGS, KIND_GPR_FLAGS), flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0), entry field widths.
- Sub-module alu_commit_fifo: parameterised DEPTH×entry storage, pointers, count, full/empty; top handles retirement decode, HI/LO, flags, trap.

## Test plan
- Reset then push GPR dest=5 data=0xDEADBEEF, wb_ready=1 -> wb_valid at t+1 with addr 5, data 0xDEADBEEF; busy falls next cycle.
- wb_ready=0, push 3 GPR entries -> in_ready=0 after 2nd push, 3rd refused; release wb_ready -> writes exit in order, data held stable while stalled.
- Push HILO high=0x00000001 low=0x80000000 -> hi_reg=1, lo_reg=0x80000000 after t+1, wb_valid never asserted.
- Push GPR_FLAGS dest=0 with N=1,Z=0,C=1,V=0 -> no wb_valid, flags=4'b1010.
- With ALU_COMMIT_TRAP_EN: GPR dest=7, in_sign=1, V=1 -> no write, trap one cycle; without macro -> write to r7, trap=0.
- Assert rst_n=0 with 2 entries buffered and wb_valid high -> all outputs return to reset values immediately, no write after release.
